prog_loader: RTL
================

# prog_loader

Instruction-memory program loader for the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them sequentially into the instruction memory's write port. It holds the processor in reset until a complete, valid image has been written. It is the writer end of the instruction-memory interface that the core's fetch stage reads.

## Interface
Parameters:
- `ADDR_W`, default 4: instruction-memory word-address width; depth is 2^ADDR_W words.
- `DATA_W`, default 32: instruction word width; fixed at 4 bytes.

Ports:
- `sysCLK`, input, 1: single clock; all state updates on the rising edge.
- `pRST`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: one-cycle pulse that begins a load, or restarts one already in progress.
- `byteIn`, input, 8: stream data byte.
- `byteValid`, input, 1: `byteIn` is valid this cycle.
- `byteReady`, output, 1: loader accepts `byteIn` this cycle.
- `imemWAddr`, output, ADDR_W: instruction-memory write word address.
- `imemWData`, output, DATA_W: instruction-memory write data.
- `imemWEn`, output, 1: instruction-memory write strobe, one cycle per word.
- `cpuHold`, output, 1: drives the core's PC reset; 1 holds the core.
- `loadDone`, output, 1: a valid image is loaded and the core is released.
- `loadErr`, output, 1: the load was aborted.

## Operation
- A byte is accepted on any cycle where `byteValid` and `byteReady` are both 1 at the clock edge.
- States: IDLE, HDR, DATA, (CHK), DONE, ERR.
- IDLE (reset state):
  - `byteReady`=0, `cpuHold`=1.
  - `start` moves to HDR.
- HDR:
  - `byteReady`=1.
  - The accepted byte is word count N.
  - N=0 or N>2^ADDR_W goes to ERR. Otherwise latch N, clear the word address and byte counter, and go to DATA.
- DATA:
  - `byteReady`=1.
  - Bytes arrive least significant first: the first byte fills bits [7:0], the fourth fills [31:24].
  - On acceptance of the 4th byte, the assembled word is registered and the next cycle presents `imemWEn`=1 with `imemWAddr` set to the current word index.
  - The word index then increments.
  - After word N-1 is accepted, go to DONE, or to CHK when checksum is enabled.
- DONE:
  - `byteReady`=0, `cpuHold`=0, `loadDone`=1.
  - Bytes are ignored.
  - `start` returns to HDR and reasserts `cpuHold`.
- ERR:
  - `byteReady`=0, `cpuHold`=1, `loadErr`=1.
  - Only `start` or `pRST` leaves ERR.
- `start` in HDR or DATA restarts at HDR. The word index and partial word are discarded, and any write already scheduled for that cycle is suppressed.
- `start` coincident with a byte handshake: `start` wins and the byte is dropped.
- The word index is ADDR_W+1 bits wide internally, so N=2^ADDR_W does not wrap. Only the low ADDR_W bits drive `imemWAddr`.

## Timing
- Reset values:
  - `byteReady`=0, `imemWEn`=0, `imemWAddr`=0, `imemWData`=0.
  - `cpuHold`=1, `loadDone`=0, `loadErr`=0.
  - State = IDLE.
- Reset asserted mid-load returns all state to IDLE immediately (asynchronously). No partial write is issued after reset.
- Write latency: `imemWEn` is asserted exactly 1 cycle after the 4th byte's handshake. Back-to-back bytes at 1 per cycle sustain a full-rate load with no stall.
- Release latency: `cpuHold` falls and `loadDone` rises 1 cycle after the last word's write strobe, so the core never fetches from an unwritten word.
- All outputs are registered. None depends combinationally on `byteValid` or `start`.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - After the last data byte, the FSM enters CHK with `byteReady`=1.
  - The accepted byte is compared with the running XOR of all 4N data bytes.
  - Match goes to DONE; mismatch goes to ERR.
  - The XOR register clears on entering HDR.
- Undefined: the CHK state and XOR register are absent. DATA goes directly to DONE after the final write.

## Structure
- Package `prog_loader_pkg`:
  - FSM state enum.
  - `BYTES_PER_WORD`=4.
  - Header field width (8).
- Sub-module `word_assembler`: 2-bit byte counter, 32-bit little-endian shift/insert register, `word_valid` pulse, synchronous clear input. The loader FSM instantiates it once.

## Test plan
- Reset, then `start`, N=2, bytes 13 00 00 00 93 00 10 00 at 1 per cycle:
  - writes addr 0=0x00000013 and addr 1=0x00100093, each `imemWEn` 1 cycle after the 4th byte;
  - `cpuHold` falls 1 cycle after the second write.
- N=0 header, then separately N=17 with ADDR_W=4: `loadErr`=1, `cpuHold`=1, no `imemWEn`. `start` clears `loadErr`.
- N=16 with ADDR_W=4: 16 writes to addresses 0..15, no wrap, `loadDone`=1.
- `start` pulsed after 6 of 8 bytes of an N=2 load: no write to addr 1; the next full load rewrites from addr 0.
- `pRST` asserted between the 4th byte and its write cycle: no `imemWEn`, all outputs at reset values.
- With `PROG_LOADER_CHECKSUM_EN`, N=1, bytes 01 02 04 08:
  - checksum 0x0F gives DONE;
  - checksum 0x0E gives ERR with `cpuHold`=1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory program loader: FSM encoding,
// stream/word geometry and a small state-classification helper.
package prog_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int HDR_W          = 8;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_HDR  = 3'd1;
  localparam state_t ST_DATA = 3'd2;
  localparam state_t ST_CHK  = 3'd3;
  localparam state_t ST_DONE = 3'd4;
  localparam state_t ST_ERR  = 3'd5;

  // States in which the loader is willing to take a stream byte.
  function automatic logic takes_bytes(state_t s);
    return (s == ST_HDR) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input plus instruction-memory write port and core-control outputs.
// master = stream source / observer, slave = the loader.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              start;
  logic [BYTE_W-1:0] byteIn;
  logic              byteValid;
  logic              byteReady;
  logic [ADDR_W-1:0] imemWAddr;
  logic [DATA_W-1:0] imemWData;
  logic              imemWEn;
  logic              cpuHold;
  logic              loadDone;
  logic              loadErr;

  modport master (
    output start, byteIn, byteValid,
    input  byteReady, imemWAddr, imemWData, imemWEn, cpuHold, loadDone, loadErr
  );

  modport slave (
    input  start, byteIn, byteValid,
    output byteReady, imemWAddr, imemWData, imemWEn, cpuHold, loadDone, loadErr
  );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// Little-endian byte-to-word assembler: three held bytes plus the live byte form
// the word, and word_valid pulses in the cycle the fourth byte is taken.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [BCNT_W-1:0]        byte_cnt;
  logic [WORD_W-BYTE_W-1:0] partial;

  // Earlier bytes shift down so byte 0 ends up in the least significant lane.
  assign word       = {byte_in, partial};
  assign word_valid = byte_en && (byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      partial  <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      partial  <= '0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + BCNT_W'(1);
      partial  <= {byte_in, partial[WORD_W-BYTE_W-1:BYTE_W]};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: header byte N, then 4N little-endian bytes written to imem
// words 0..N-1; core held until done. Optional trailing XOR byte: PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
)(
  input  logic         sysCLK,
  input  logic         pRST,
  prog_loader_if.slave bus
);

  localparam int          CNT_W     = ADDR_W + 1;
  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  state_t            state, next_state;
  logic [CNT_W-1:0]  n_words, word_idx;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              byte_ready, wen, cpu_hold, load_done, load_err;

  logic              accept, hdr_ok, last_word;
  logic [31:0]       n_in;
  logic              asm_en, asm_clear, word_valid;
  logic [WORD_W-1:0] word;

  // start always wins over a coincident byte, which is then dropped.
  assign accept    = bus.byteValid && byte_ready && !bus.start;
  assign n_in      = 32'(bus.byteIn);
  assign hdr_ok    = (n_in != 32'd0) && (n_in <= MAX_WORDS);
  assign last_word = (word_idx == n_words - CNT_W'(1));
  assign asm_en    = accept && (state == ST_DATA);
  assign asm_clear = bus.start || (state != ST_DATA);

  word_assembler u_asm (
    .clk        (sysCLK),
    .rst        (pRST),
    .clear      (asm_clear),
    .byte_en    (asm_en),
    .byte_in    (bus.byteIn),
    .word       (word),
    .word_valid (word_valid)
  );

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;

  always_ff @(posedge sysCLK or posedge pRST) begin
    if (pRST)           csum <= '0;
    else if (bus.start) csum <= '0;
    else if (asm_en)    csum <= csum ^ bus.byteIn;
  end
`endif

  // NOTE: next_state gets a default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    if (bus.start) begin
      next_state = ST_HDR;
    end else begin
      case (state)
        ST_HDR:  if (accept) next_state = hdr_ok ? ST_DATA : ST_ERR;
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_DATA: if (word_valid && last_word) next_state = ST_CHK;
        ST_CHK:  if (accept) next_state = (bus.byteIn == csum) ? ST_DONE : ST_ERR;
`else
        ST_DATA: if (word_valid && last_word) next_state = ST_DONE;
`endif
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge sysCLK or posedge pRST) begin
    if (pRST) begin
      state      <= ST_IDLE;
      byte_ready <= 1'b0;
      wen        <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      n_words    <= '0;
      word_idx   <= '0;
    end else begin
      state      <= next_state;
      byte_ready <= takes_bytes(next_state);
      load_err   <= (next_state == ST_ERR);
      // Release only once DONE has lasted a cycle, i.e. after the final write strobe.
      load_done  <= (state == ST_DONE) && (next_state == ST_DONE);
      cpu_hold   <= !((state == ST_DONE) && (next_state == ST_DONE));
      wen        <= word_valid;
      if (word_valid) begin
        waddr <= word_idx[ADDR_W-1:0];
        wdata <= DATA_W'(word);
      end
      if (bus.start) begin
        word_idx <= '0;
      end else if ((state == ST_HDR) && accept) begin
        word_idx <= '0;
        if (hdr_ok) n_words <= CNT_W'(n_in);
      end else if (word_valid) begin
        word_idx <= word_idx + CNT_W'(1);
      end
    end
  end

  assign bus.byteReady = byte_ready;
  assign bus.imemWEn   = wen;
  assign bus.imemWAddr = waddr;
  assign bus.imemWData = wdata;
  assign bus.cpuHold   = cpu_hold;
  assign bus.loadDone  = load_done;
  assign bus.loadErr   = load_err;

endmodule
